// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared types and constants for the servo sweep controller
package servo_pkg;

    localparam int ANGLE_W    = 8;
    localparam int DIST_W_MAX = 64;

    // Reported in place of a distance when the range sensor never answers
    localparam logic [DIST_W_MAX-1:0] DIST_ALL_ONES = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_SETTLE,
        ST_MEASURE,
        ST_REPORT
    } sweep_state_e;

endpackage

// File: rtl/servo_sweep_ctrl_if.sv
// rtl/servo_sweep_ctrl_if.sv - record output channel of the servo sweep controller
interface servo_sweep_ctrl_if #(
    parameter int DIST_W = 16
);
    import servo_pkg::*;

    logic               rec_valid;
    logic               rec_ready;
    logic [ANGLE_W-1:0] rec_angle;
    logic [DIST_W-1:0]  rec_dist;

    modport master (
        output rec_valid,
        output rec_angle,
        output rec_dist,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_angle,
        input  rec_dist,
        output rec_ready
    );

endinterface

// File: rtl/sweep_angle_gen.sv
// rtl/sweep_angle_gen.sv - commanded angle register with bounded up/down stepping
module sweep_angle_gen
    import servo_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [ANGLE_W-1:0] angle_min_i,
    input  logic [ANGLE_W-1:0] angle_max_i,
    input  logic [ANGLE_W-1:0] step_size_i,
    output logic [ANGLE_W-1:0] angle_o
);

    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic [ANGLE_W-1:0] min_q, max_q, step_q;
    logic               dir_down_q, dir_down_d;
    logic [ANGLE_W:0]   sum_ext;
    logic [ANGLE_W:0]   diff_ext;

    // One extra bit catches overflow going up and borrow going down
    assign sum_ext  = {1'b0, angle_q} + {1'b0, step_q};
    assign diff_ext = {1'b0, angle_q} - {1'b0, step_q};

    // Next angle: clamp at either bound and reverse direction there
    always_comb begin
        angle_d    = angle_q;
        dir_down_d = dir_down_q;
        if (step_q == '0 || min_q >= max_q) begin
            angle_d    = min_q;
            dir_down_d = 1'b0;
        end else if (!dir_down_q) begin
            if (sum_ext >= {1'b0, max_q}) begin
                angle_d    = max_q;
                dir_down_d = 1'b1;
            end else begin
                angle_d = sum_ext[ANGLE_W-1:0];
            end
        end else begin
            if (diff_ext[ANGLE_W] || diff_ext[ANGLE_W-1:0] <= min_q) begin
                angle_d    = min_q;
                dir_down_d = 1'b0;
            end else begin
                angle_d = diff_ext[ANGLE_W-1:0];
            end
        end
    end

    // Bounds are captured on load; the angle only moves on an explicit step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle_q    <= '0;
            dir_down_q <= 1'b0;
            min_q      <= '0;
            max_q      <= '0;
            step_q     <= '0;
        end else if (load_i) begin
            angle_q    <= angle_min_i;
            dir_down_q <= 1'b0;
            min_q      <= angle_min_i;
            max_q      <= angle_max_i;
            step_q     <= step_size_i;
        end else if (step_i) begin
            angle_q    <= angle_d;
            dir_down_q <= dir_down_d;
        end
    end

    assign angle_o = angle_q;

endmodule

// File: rtl/servo_sweep_ctrl.sv
// rtl/servo_sweep_ctrl.sv - sweeps a servo between bounds and records a range at each stop
module servo_sweep_ctrl
    import servo_pkg::*;
#(
    parameter int TIMEOUT_FRAMES = 4,
    parameter int DIST_W         = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [ANGLE_W-1:0] angle_min,
    input  logic [ANGLE_W-1:0] angle_max,
    input  logic [ANGLE_W-1:0] step,
    input  logic [3:0]         settle_frames,
    input  logic               cycle_done,
    output logic [ANGLE_W-1:0] angle,
    output logic               meas_start,
    input  logic               meas_done,
    input  logic [DIST_W-1:0]  meas_data,
    output logic               busy,
    servo_sweep_ctrl_if.master rec
);

    // Frame counter is shared by settling and the measurement timeout
    localparam int CNT_W = ($clog2(TIMEOUT_FRAMES + 1) > 4) ? $clog2(TIMEOUT_FRAMES + 1) : 4;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_FRAMES);

    sweep_state_e       state_q;
    logic [3:0]         settle_q;
    logic [CNT_W-1:0]   frame_cnt_q;
    logic [CNT_W-1:0]   frame_cnt_inc;
    logic               step_pending_q;
    logic               meas_start_q;
    logic               rec_valid_q;
    logic [ANGLE_W-1:0] rec_angle_q;
    logic [DIST_W-1:0]  rec_dist_q;
    logic               load_angle;
    logic               apply_step;

    assign frame_cnt_inc = frame_cnt_q + CNT_W'(1);
    assign load_angle    = (state_q == ST_IDLE) && enable;
    assign apply_step    = (state_q == ST_MOVE) && step_pending_q;

    sweep_angle_gen u_angle_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load_angle),
        .step_i      (apply_step),
        .angle_min_i (angle_min),
        .angle_max_i (angle_max),
        .step_size_i (step),
        .angle_o     (angle)
    );

    // Sweep sequencer: move, wait for the servo to settle, measure, hand off a record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            settle_q       <= '0;
            frame_cnt_q    <= '0;
            step_pending_q <= 1'b0;
            meas_start_q   <= 1'b0;
            rec_valid_q    <= 1'b0;
            rec_angle_q    <= '0;
            rec_dist_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        settle_q       <= settle_frames;
                        step_pending_q <= 1'b0;
                        state_q        <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    step_pending_q <= 1'b1;
                    frame_cnt_q    <= '0;
                    if (settle_q == 4'd0) begin
                        meas_start_q <= 1'b1;
                        state_q      <= ST_MEASURE;
                    end else begin
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cycle_done) begin
                        if (frame_cnt_inc == CNT_W'(settle_q)) begin
                            frame_cnt_q  <= '0;
                            meas_start_q <= 1'b1;
                            state_q      <= ST_MEASURE;
                        end else begin
                            frame_cnt_q <= frame_cnt_inc;
                        end
                    end
                end
                ST_MEASURE: begin
                    meas_start_q <= 1'b0;
                    // A done in the same clk as the request cannot belong to it
                    if (meas_done && !meas_start_q) begin
                        rec_dist_q  <= meas_data;
                        rec_angle_q <= angle;
                        rec_valid_q <= 1'b1;
                        state_q     <= ST_REPORT;
                    end else if (cycle_done) begin
                        if (frame_cnt_inc == TIMEOUT_CNT) begin
                            rec_dist_q  <= DIST_ALL_ONES[DIST_W-1:0];
                            rec_angle_q <= angle;
                            rec_valid_q <= 1'b1;
                            state_q     <= ST_REPORT;
                        end else begin
                            frame_cnt_q <= frame_cnt_inc;
                        end
                    end
                end
                ST_REPORT: begin
                    if (rec.rec_ready) begin
                        rec_valid_q <= 1'b0;
                        state_q     <= enable ? ST_MOVE : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign meas_start    = meas_start_q;
    assign busy          = (state_q != ST_IDLE);
    assign rec.rec_valid = rec_valid_q;
    assign rec.rec_angle = rec_angle_q;
    assign rec.rec_dist  = rec_dist_q;

endmodule

// File: doc/servo_sweep_ctrl.md
SERVO_SWEEP_CTRL -- requirements
Module: servo_sweep_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_FRAMES, default 4, meaning the number of servo frames to wait for meas_done before aborting.
REQ-002 SHALL have parameter DIST_W, default 16, meaning the width of the distance result.
REQ-003 SHALL have port clk, input, 1, the system clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-005 SHALL have port enable, input, 1, level; starts and continues sweeping while high.
REQ-006 SHALL have port angle_min / angle_max, input, 8 each, sweep bounds sampled in IDLE only.
REQ-007 SHALL have port step, input, 8, angle increment sampled in IDLE only.
REQ-008 SHALL have port settle_frames, input, 4, servo frames to wait after each move (sampled in IDLE).
REQ-009 SHALL have port cycle_done, input, 1, one-clk pulse per servo PWM frame from the servo driver.
REQ-010 SHALL have port angle, output, 8, the commanded angle to the servo driver.
REQ-011 SHALL have port meas_start, output, 1, one-clk pulse requesting a range measurement.
REQ-012 SHALL have port meas_done / meas_data, input, 1 / DIST_W, measurement complete pulse and its result.
REQ-013 SHALL have port rec_valid / rec_ready, output / input, 1 each, record handshake.
REQ-014 SHALL have port rec_angle / rec_dist, output, 8 / DIST_W, record payload.
REQ-015 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, MOVE, SETTLE, MEASURE and REPORT.
REQ-017 SHALL go IDLE->MOVE when enable=1, latching bounds, step and settle_frames, setting angle=angle_min and direction=up, without stepping on that first MOVE.
REQ-018 SHALL, in MOVE, apply the pending step (if any), clear the frame count, and go to SETTLE next cycle (MOVE lasts exactly 1 clk).
REQ-019 SHALL, in SETTLE, count cycle_done pulses and go to MEASURE on the cycle the count reaches settle_frames; settle_frames=0 means MEASURE directly after MOVE.
REQ-020 SHALL assert meas_start for exactly the first clk in MEASURE; meas_done in that same clk SHALL be ignored.
REQ-021 SHALL, on meas_done in MEASURE, capture meas_data into rec_dist and rec_angle=angle, then go to REPORT.
REQ-022 SHALL, if TIMEOUT_FRAMES cycle_done pulses pass in MEASURE without meas_done, set rec_dist=all-ones and go to REPORT.
REQ-023 SHALL hold rec_valid high in REPORT with a stable payload until rec_ready=1; on handshake, go to MOVE if enable=1, else IDLE.
REQ-024 SHALL compute next angle with 9-bit arithmetic: up: angle+step; if it is >= angle_max, set angle=angle_max and direction=down.
REQ-025 SHALL compute down: if angle-step <= angle_min (including borrow), set angle=angle_min and direction=up.
REQ-026 SHALL, when step=0 or angle_min>=angle_max, hold angle at angle_min and continue measuring every iteration.
REQ-027 SHALL, on enable deassert mid-sweep, complete the current iteration through the REPORT handshake, then go to IDLE.
REQ-028 SHALL keep angle stable outside MOVE; SHALL ignore meas_done outside MEASURE.

Reset
REQ-029 SHALL, on rst_n low, immediately set state=IDLE, angle=0, direction=up, counters=0, meas_start=0, rec_valid=0, rec_angle=0, rec_dist=0, busy=0.
REQ-030 SHALL, on reset release, leave IDLE no earlier than the first clk edge with enable=1.

Structure
REQ-031 SHALL place the state enum, ANGLE_W=8 and the all-ones distance constant in shared package servo_pkg.
REQ-032 SHALL use one sub-module, sweep_angle_gen, holding the angle register, the direction flag and the bound-clamping step logic.

Verification
REQ-033 SHALL cover: min=0, max=30, step=10, settle=0, instant meas_done -> rec_angle sequence 0,10,20,30,20,10,0,10.
REQ-034 SHALL cover: min=5, max=20, step=7 -> rec_angle sequence 5,12,19,20,13,6,5 (clamped both ends).
REQ-035 SHALL cover: settle=3, meas_done never returned, TIMEOUT_FRAMES=4 -> meas_start 3 frames after MOVE, and record rec_dist=16'hFFFF after 4 more frames.
REQ-036 SHALL cover: rec_ready held low 50 clks -> rec_valid stays high with a constant payload and angle unchanged.
REQ-037 SHALL cover: enable dropped during SETTLE -> one record emitted, then busy=0 and state IDLE.
REQ-038 SHALL cover: rst_n pulsed low during MEASURE -> all outputs are zero asynchronously, and a later meas_done produces no record.
